if_fetch_unit: RTL and testbench

- Instruction-fetch controller for the pipelined core. It consumes the program counter value and drives the next-PC value back into the PC register, which has no enable: holding the PC means driving pc_next = pc_cur.
- Issues one-outstanding requests to instruction memory and loads fetched instructions into the IF/ID pipeline register.
- Handles ID-stage back-pressure and branch/jump redirects.

---
 rtl/if_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller: one outstanding imem request, IF/ID pipeline
// register with a one-entry skid buffer, and redirect (branch/jump) flushing.
module if_fetch_unit #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     PC_STEP   = 4,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [ILEN-1:0] ifid_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP_X = XLEN'(PC_STEP);

  state_e          state_q, state_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [ILEN-1:0] skid_q, skid_d;

  logic            slot_free_s;
  logic            load_s;
  logic [ILEN-1:0] load_instr_s;
  logic [XLEN-1:0] pc_inc_s;

  assign slot_free_s = ~ifid_valid_q | ~stall_id;
  assign pc_inc_s    = pc_cur + PC_STEP_X;
  assign imem_addr   = pc_cur;
  assign imem_req    = ~reset & (state_q == S_REQ) & ~redirect_valid;

  assign ifid_valid  = ifid_valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;

  // Next-state, next-PC and IF/ID update; redirect overrides everything.
  always_comb begin
    state_d      = state_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    skid_d       = skid_q;
    pc_next      = pc_cur;
    load_s       = 1'b0;
    load_instr_s = imem_rdata;

    if (redirect_valid) begin
      pc_next      = redirect_pc;
      ifid_valid_d = 1'b0;
      skid_d       = {ILEN{1'b0}};
      // An in-flight response that has not yet returned must still be swallowed.
      if (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rvalid) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (slot_free_s) begin
              load_s       = 1'b1;
              load_instr_s = imem_rdata;
              pc_next      = pc_inc_s;
              state_d      = S_REQ;
            end else begin
              skid_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (slot_free_s) begin
            load_s       = 1'b1;
            load_instr_s = skid_q;
            pc_next      = pc_inc_s;
            skid_d       = {ILEN{1'b0}};
            state_d      = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DROP;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase

      if (load_s) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = pc_cur;
        ifid_instr_d = load_instr_s;
      end else if (!stall_id) begin
        ifid_valid_d = 1'b0;
      end else begin
        ifid_valid_d = ifid_valid_q;
      end
    end
  end

  // State, IF/ID pipeline register and skid buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= {XLEN{1'b0}};
      ifid_instr_q <= NOP_INSTR;
      skid_q       <= {ILEN{1'b0}};
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand-written
// wrap/reset sequences, and randomized traffic against a reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [63:0] pc_q;
  logic [63:0] pc_next;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;

  logic        pc_load_en;
  logic [63:0] pc_load_val;

  int n_checks;
  int n_pass;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc_cur         (pc_q),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The core's PC register (no enable), with a bench-side override for preloading.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 64'd0;
    else if (pc_load_en) pc_q <= pc_load_val;
    else pc_q <= pc_next;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic clear_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    pc_load_en = 1'b0; pc_load_val = 64'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    #1;
    chk("reset_req", 64'(imem_req), 64'd0);
    chk("reset_valid", 64'(ifid_valid), 64'd0);
    chk("reset_instr", 64'(ifid_instr), 64'(NOP));
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
    logic        req;
    logic [63:0] pcc;
    logic [63:0] pcn;
    logic        v;
    logic [63:0] ipc;
    logic [31:0] ins;
  } vec_t;

  vec_t vt [0:20];

  // Reference model state (transaction-level view of the fetch unit).
  bit          m_out, m_disc, m_bufv, m_v, m_slot, m_deliver, m_loaded, m_req;
  logic [31:0] m_bufd, m_ins;
  logic [63:0] m_pc, m_pcn;
  bit          mem_busy;
  int          mem_cnt;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    clear_inputs();

    //          gnt   rv    rdata          stall redir rpc         req   pc_cur       pc_next      v     ifid_pc      ifid_instr
    vt[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h0,       64'h0,       1'b0, 64'h0,       NOP};
    vt[1]  = '{1'b0, 1'b1, 32'h11,        1'b0, 1'b0, 64'h0,      1'b0, 64'h0,       64'h4,       1'b0, 64'h0,       NOP};
    vt[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h4,       64'h4,       1'b1, 64'h0,       32'h11};
    vt[3]  = '{1'b0, 1'b1, 32'h22,        1'b0, 1'b0, 64'h0,      1'b0, 64'h4,       64'h8,       1'b0, 64'h0,       32'h11};
    vt[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h8,       64'h8,       1'b1, 64'h4,       32'h22};
    vt[5]  = '{1'b0, 1'b1, 32'h33,        1'b0, 1'b0, 64'h0,      1'b0, 64'h8,       64'hC,       1'b0, 64'h4,       32'h22};
    vt[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0,      1'b1, 64'hC,       64'hC,       1'b1, 64'h8,       32'h33};
    vt[7]  = '{1'b0, 1'b1, 32'h44,        1'b1, 1'b0, 64'h0,      1'b0, 64'hC,       64'hC,       1'b1, 64'h8,       32'h33};
    vt[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0,      1'b0, 64'hC,       64'hC,       1'b1, 64'h8,       32'h33};
    vt[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 64'hC,       64'h10,      1'b1, 64'h8,       32'h33};
    vt[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h10,      64'h10,      1'b1, 64'hC,       32'h44};
    vt[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h10,      64'h10,      1'b0, 64'hC,       32'h44};
    vt[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 64'h100,    1'b0, 64'h10,      64'h100,     1'b0, 64'hC,       32'h44};
    vt[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b0, 64'h100,     64'h100,     1'b0, 64'hC,       32'h44};
    vt[14] = '{1'b0, 1'b1, 32'hDEAD,      1'b0, 1'b0, 64'h0,      1'b0, 64'h100,     64'h100,     1'b0, 64'hC,       32'h44};
    vt[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h100,     64'h100,     1'b0, 64'hC,       32'h44};
    vt[16] = '{1'b0, 1'b1, 32'hBEEF,      1'b0, 1'b1, 64'h200,    1'b0, 64'h100,     64'h200,     1'b0, 64'hC,       32'h44};
    vt[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h200,     64'h200,     1'b0, 64'hC,       32'h44};
    vt[18] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,      1'b1, 64'h200,     64'h200,     1'b0, 64'hC,       32'h44};
    vt[19] = '{1'b0, 1'b1, 32'h55,        1'b1, 1'b0, 64'h0,      1'b0, 64'h200,     64'h204,     1'b0, 64'hC,       32'h44};
    vt[20] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0,      1'b1, 64'h204,     64'h204,     1'b1, 64'h200,     32'h55};

    do_reset();

    // Directed table: zero-wait fetch, back-pressure, redirects.
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      imem_gnt       = vt[i].gnt;
      imem_rvalid    = vt[i].rv;
      imem_rdata     = vt[i].rdata;
      stall_id       = vt[i].stall;
      redirect_valid = vt[i].redir;
      redirect_pc    = vt[i].rpc;
      #1;
      chk($sformatf("v%0d_req", i),   64'(imem_req),   64'(vt[i].req));
      chk($sformatf("v%0d_addr", i),  imem_addr,       vt[i].pcc);
      chk($sformatf("v%0d_pcnext", i), pc_next,        vt[i].pcn);
      chk($sformatf("v%0d_valid", i), 64'(ifid_valid), 64'(vt[i].v));
      chk($sformatf("v%0d_ipc", i),   ifid_pc,         vt[i].ipc);
      chk($sformatf("v%0d_instr", i), 64'(ifid_instr), 64'(vt[i].ins));
    end

    // PC wrap at the top of the address space.
    do_reset();
    @(negedge clk);
    pc_load_en = 1'b1; pc_load_val = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    pc_load_en = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("wrap_req", 64'(imem_req), 64'd1);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h66;
    #1;
    chk("wrap_pcnext", pc_next, 64'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("wrap_ipc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", 64'(ifid_instr), 64'h66);
    chk("wrap_addr0", imem_addr, 64'd0);

    // Reset while waiting, then a stale response right after reset.
    @(negedge clk);
    imem_gnt = 1'b1;
    #1;
    chk("rst_pre_req", 64'(imem_req), 64'd1);
    @(negedge clk);
    imem_gnt = 1'b0; reset = 1'b1;
    #1;
    chk("rst_mid_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h77;
    #1;
    chk("rst_stale_req", 64'(imem_req), 64'd1);
    chk("rst_stale_addr", imem_addr, 64'd0);
    chk("rst_stale_instr", 64'(ifid_instr), 64'(NOP));
    chk("rst_stale_valid", 64'(ifid_valid), 64'd0);
    chk("rst_stale_pcnext", pc_next, 64'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("rst_after_req", 64'(imem_req), 64'd1);
    chk("rst_after_valid", 64'(ifid_valid), 64'd0);
    chk("rst_after_instr", 64'(ifid_instr), 64'(NOP));

    // Randomized traffic against the reference model.
    do_reset();
    m_out = 0; m_disc = 0; m_bufv = 0; m_bufd = 32'd0;
    m_v = 0; m_pc = 64'd0; m_ins = NOP;
    mem_busy = 0; mem_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      imem_gnt       = ($urandom_range(0, 3) != 0);
      stall_id       = ($urandom_range(0, 9) < 4);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = {$urandom, $urandom} & ~64'h3;
      imem_rvalid    = mem_busy && (mem_cnt == 1);
      imem_rdata     = $urandom;

      m_req     = !m_out && !m_bufv && !redirect_valid;
      m_slot    = !m_v || !stall_id;
      m_deliver = m_slot && ((m_out && !m_disc && imem_rvalid) || m_bufv);
      m_pcn     = redirect_valid ? redirect_pc : (m_deliver ? pc_q + 64'd4 : pc_q);
      #1;
      chk("rnd_req",    64'(imem_req),   64'(m_req));
      chk("rnd_addr",   imem_addr,       pc_q);
      chk("rnd_pcnext", pc_next,         m_pcn);
      chk("rnd_valid",  64'(ifid_valid), 64'(m_v));
      chk("rnd_ipc",    ifid_pc,         m_pc);
      chk("rnd_instr",  64'(ifid_instr), 64'(m_ins));

      if (redirect_valid) begin
        if (m_out && !imem_rvalid) m_disc = 1;
        else begin m_out = 0; m_disc = 0; end
        m_bufv = 0;
        m_v    = 0;
      end else begin
        m_loaded = 0;
        if (!m_out && !m_bufv) begin
          if (imem_gnt) m_out = 1;
        end else if (m_out) begin
          if (imem_rvalid) begin
            m_out = 0;
            if (m_disc) m_disc = 0;
            else if (m_slot) begin m_v = 1; m_pc = pc_q; m_ins = imem_rdata; m_loaded = 1; end
            else begin m_bufv = 1; m_bufd = imem_rdata; end
          end
        end else if (m_slot) begin
          m_v = 1; m_pc = pc_q; m_ins = m_bufd; m_bufv = 0; m_loaded = 1;
        end
        if (!m_loaded && !stall_id) m_v = 0;
      end

      if (imem_rvalid) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (m_req && imem_gnt) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(1, 3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
